// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID register with a one-entry stall buffer.
// Define IF_REDIRECT_EN to add the redirect/flush path (i_redirect, i_redirectPc).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemData,
    input  logic        i_stall,
`ifdef IF_REDIRECT_EN
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
`endif
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_sa,
    output logic [5:0]  o_fn,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm,
    output logic [25:0] o_target
);

    localparam int unsigned XLEN = 32;

`ifdef IF_REDIRECT_EN
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DISCARD = 2'd2} state_t;
`else
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;
`endif

    state_t          state_q, state_nxt;
    logic            req_q, req_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] addr_q, addr_nxt;
    logic [XLEN-1:0] buf_word_q, buf_word_nxt;
    logic [XLEN-1:0] buf_pc_q, buf_pc_nxt;
    logic            valid_q, valid_nxt;
    logic [XLEN-1:0] inst_q, inst_nxt;
    logic [XLEN-1:0] ifpc_q, ifpc_nxt;
    logic [XLEN-1:0] imm_q, imm_nxt;
    logic            accept;

    // An ack only counts while a request is actually presented.
    assign accept = req_q & i_imemAck;

    function automatic logic [XLEN-1:0] ext_imm(input logic [XLEN-1:0] w);
        logic [XLEN-1:0] r;
        case (w[31:26])
            6'h0C, 6'h0D, 6'h0E: r = {16'h0000, w[15:0]};
            6'h0F:               r = {w[15:0], 16'h0000};
            default:             r = {{16{w[15]}}, w[15:0]};
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            FETCH:   if (accept && i_stall) state_nxt = HOLD;
            HOLD:    if (!i_stall) state_nxt = FETCH;
`ifdef IF_REDIRECT_EN
            DISCARD: if (i_imemAck) state_nxt = FETCH;
`endif
            default: state_nxt = FETCH;
        endcase
`ifdef IF_REDIRECT_EN
        // A request left hanging by the redirect must still be completed and dropped.
        if (i_redirect) begin
            if (req_q && !i_imemAck) state_nxt = DISCARD;
            else                     state_nxt = FETCH;
        end
`endif
    end

    // Output / datapath next values
    always_comb begin
        pc_nxt       = pc_q;
        buf_word_nxt = buf_word_q;
        buf_pc_nxt   = buf_pc_q;
        valid_nxt    = valid_q;
        inst_nxt     = inst_q;
        ifpc_nxt     = ifpc_q;
        case (state_q)
            FETCH: begin
                if (accept && !i_stall) begin
                    valid_nxt = 1'b1;
                    inst_nxt  = i_imemData;
                    ifpc_nxt  = pc_q;
                    pc_nxt    = pc_q + XLEN'(PC_STEP);
                end else if (accept) begin
                    buf_word_nxt = i_imemData;
                    buf_pc_nxt   = pc_q;
                end else if (!i_stall) begin
                    valid_nxt = 1'b0;
                    inst_nxt  = '0;
                    ifpc_nxt  = '0;
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    valid_nxt    = 1'b1;
                    inst_nxt     = buf_word_q;
                    ifpc_nxt     = buf_pc_q;
                    pc_nxt       = buf_pc_q + XLEN'(PC_STEP);
                    buf_word_nxt = '0;
                    buf_pc_nxt   = '0;
                end
            end
            default: begin
                if (!i_stall) begin
                    valid_nxt = 1'b0;
                    inst_nxt  = '0;
                    ifpc_nxt  = '0;
                end
            end
        endcase
`ifdef IF_REDIRECT_EN
        if (i_redirect) begin
            valid_nxt    = 1'b0;
            inst_nxt     = '0;
            ifpc_nxt     = '0;
            buf_word_nxt = '0;
            buf_pc_nxt   = '0;
            pc_nxt       = i_redirectPc;
        end
`endif
        imm_nxt  = ext_imm(inst_nxt);
        req_nxt  = (state_nxt != HOLD);
        addr_nxt = pc_nxt;
`ifdef IF_REDIRECT_EN
        if (state_nxt == DISCARD) addr_nxt = addr_q;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            buf_word_q <= '0;
            buf_pc_q   <= '0;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            ifpc_q     <= '0;
            imm_q      <= '0;
        end else begin
            req_q      <= req_nxt;
            pc_q       <= pc_nxt;
            addr_q     <= addr_nxt;
            buf_word_q <= buf_word_nxt;
            buf_pc_q   <= buf_pc_nxt;
            valid_q    <= valid_nxt;
            inst_q     <= inst_nxt;
            ifpc_q     <= ifpc_nxt;
            imm_q      <= imm_nxt;
        end
    end

    assign o_imemReq  = req_q;
    assign o_imemAddr = addr_q;
    assign o_valid    = valid_q;
    assign o_pc       = ifpc_q;
    assign o_opcode   = inst_q[31:26];
    assign o_rs       = inst_q[25:21];
    assign o_rt       = inst_q[20:16];
    assign o_rd       = inst_q[15:11];
    assign o_sa       = inst_q[10:6];
    assign o_fn       = inst_q[5:0];
    assign o_imm      = imm_q;
    assign o_target   = inst_q[25:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand-written reset/field/redirect sequences.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_imemReq;
    logic [31:0] o_imemAddr;
    logic        i_imemAck;
    logic [31:0] i_imemData;
    logic        i_stall;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [5:0]  o_opcode;
    logic [4:0]  o_sa;
    logic [5:0]  o_fn;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [31:0] o_imm;
    logic [25:0] o_target;
`ifdef IF_REDIRECT_EN
    logic        i_redirect;
    logic [31:0] i_redirectPc;
`endif

    logic        ack_en;
    logic        ovr_en;
    logic [31:0] ovr_data;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Memory image: 0x100 holds ORI r2,r1,5; everything else is ADDI r1,r0,addr[15:0].
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h100) return 32'h3422_0005;
        return {16'h2001, a[15:0]};
    endfunction

    assign i_imemAck  = ack_en;
    assign i_imemData = ovr_en ? ovr_data : word_at(o_imemAddr);

    if_stage #(.RESET_PC(32'h100), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_imemReq(o_imemReq), .o_imemAddr(o_imemAddr),
        .i_imemAck(i_imemAck), .i_imemData(i_imemData),
        .i_stall(i_stall),
`ifdef IF_REDIRECT_EN
        .i_redirect(i_redirect), .i_redirectPc(i_redirectPc),
`endif
        .o_valid(o_valid), .o_pc(o_pc), .o_opcode(o_opcode), .o_sa(o_sa),
        .o_fn(o_fn), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_imm(o_imm), .o_target(o_target)
    );

    typedef struct {
        logic        stall;
        logic        ack;
        logic        ovr;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_imm;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic stall, input logic ack);
        i_stall = stall;
        ack_en  = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc);
        check({tag, ".req"},   32'(o_imemReq),  32'(req));
        check({tag, ".addr"},  o_imemAddr,      addr);
        check({tag, ".valid"}, 32'(o_valid),    32'(valid));
        check({tag, ".pc"},    o_pc,            pc);
    endtask

    function automatic vec_t mk(input logic st, input logic ak, input logic ov, input logic [31:0] d,
                                input logic rq, input logic [31:0] ad, input logic vl,
                                input logic [31:0] pc, input logic [31:0] im);
        vec_t v;
        v.stall = st; v.ack = ak; v.ovr = ov; v.data = d;
        v.exp_req = rq; v.exp_addr = ad; v.exp_valid = vl; v.exp_pc = pc; v.exp_imm = im;
        return v;
    endfunction

    initial begin
        // stall, ack, ovr, data | req, addr, valid, pc, imm
        vecs[0]  = mk(0, 1, 0, 0,            1, 32'h108, 1, 32'h104, 32'h104);
        vecs[1]  = mk(1, 1, 0, 0,            0, 32'h108, 1, 32'h104, 32'h104);
        vecs[2]  = mk(1, 1, 0, 0,            0, 32'h108, 1, 32'h104, 32'h104);
        vecs[3]  = mk(1, 1, 0, 0,            0, 32'h108, 1, 32'h104, 32'h104);
        vecs[4]  = mk(0, 1, 0, 0,            1, 32'h10C, 1, 32'h108, 32'h108);
        vecs[5]  = mk(0, 1, 0, 0,            1, 32'h110, 1, 32'h10C, 32'h10C);
        vecs[6]  = mk(0, 0, 0, 0,            1, 32'h110, 0, 32'h0,   32'h0);
        vecs[7]  = mk(0, 0, 0, 0,            1, 32'h110, 0, 32'h0,   32'h0);
        vecs[8]  = mk(0, 1, 0, 0,            1, 32'h114, 1, 32'h110, 32'h110);
        vecs[9]  = mk(1, 0, 0, 0,            1, 32'h114, 1, 32'h110, 32'h110);
        vecs[10] = mk(0, 0, 0, 0,            1, 32'h114, 0, 32'h0,   32'h0);
        vecs[11] = mk(0, 1, 0, 0,            1, 32'h118, 1, 32'h114, 32'h114);
        vecs[12] = mk(0, 1, 1, 32'h2001_FFFF, 1, 32'h11C, 1, 32'h118, 32'hFFFF_FFFF);
        vecs[13] = mk(0, 1, 1, 32'h3C01_1234, 1, 32'h120, 1, 32'h11C, 32'h1234_0000);
        vecs[14] = mk(0, 1, 1, 32'h3021_8000, 1, 32'h124, 1, 32'h120, 32'h0000_8000);
        vecs[15] = mk(0, 1, 1, 32'h2001_8000, 1, 32'h128, 1, 32'h124, 32'hFFFF_8000);
        vecs[16] = mk(1, 1, 0, 0,            0, 32'h128, 1, 32'h124, 32'hFFFF_8000);

        rst_n = 1'b0; i_stall = 1'b0; ack_en = 1'b1; ovr_en = 1'b0; ovr_data = '0;
`ifdef IF_REDIRECT_EN
        i_redirect = 1'b0; i_redirectPc = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_if("reset", 1'b0, 32'h100, 1'b0, 32'h0);
        check("reset.imm", o_imm, 32'h0);
        check("reset.opcode", 32'(o_opcode), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1);
        check_if("first", 1'b1, 32'h100, 1'b0, 32'h0);
        cyc(0, 1);
        check_if("ori", 1'b1, 32'h104, 1'b1, 32'h100);
        check("ori.opcode", 32'(o_opcode), 32'h0D);
        check("ori.rs",     32'(o_rs),     32'h1);
        check("ori.rt",     32'(o_rt),     32'h2);
        check("ori.imm",    o_imm,         32'h5);
        check("ori.fn",     32'(o_fn),     32'h5);
        check("ori.target", 32'(o_target), 32'h022_0005);

        for (int i = 0; i < NV; i++) begin
            ovr_en   = vecs[i].ovr;
            ovr_data = vecs[i].data;
            cyc(vecs[i].stall, vecs[i].ack);
            check_if($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                     vecs[i].exp_valid, vecs[i].exp_pc);
            check($sformatf("vec%0d.imm", i), o_imm, vecs[i].exp_imm);
        end

        // Asynchronous reset in the middle of HOLD
        ovr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_if("rst_hold", 1'b0, 32'h100, 1'b0, 32'h0);
        check("rst_hold.imm", o_imm, 32'h0);
        i_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1);
        check_if("restart1", 1'b1, 32'h100, 1'b0, 32'h0);
        cyc(0, 1);
        check_if("restart2", 1'b1, 32'h104, 1'b1, 32'h100);
        check("restart2.imm", o_imm, 32'h5);

        // R-type field split
        ovr_en = 1'b1; ovr_data = 32'h0022_1942;
        cyc(0, 1);
        check_if("rtype", 1'b1, 32'h108, 1'b1, 32'h104);
        check("rtype.rs", 32'(o_rs), 32'h1);
        check("rtype.rt", 32'(o_rt), 32'h2);
        check("rtype.rd", 32'(o_rd), 32'h3);
        check("rtype.sa", 32'(o_sa), 32'h5);
        check("rtype.fn", 32'(o_fn), 32'h2);
        check("rtype.imm", o_imm, 32'h0000_1942);
        check("rtype.target", 32'(o_target), 32'h022_1942);
        ovr_en = 1'b0;
        cyc(0, 1);
        check_if("seq108", 1'b1, 32'h10C, 1'b1, 32'h108);

`ifdef IF_REDIRECT_EN
        // Redirect while the 0x10C request is outstanding
        i_redirect = 1'b1; i_redirectPc = 32'h200;
        cyc(0, 0);
        check_if("redir", 1'b1, 32'h10C, 1'b0, 32'h0);
        i_redirect = 1'b0;
        cyc(0, 0);
        check_if("discard_wait", 1'b1, 32'h10C, 1'b0, 32'h0);
        cyc(0, 1);
        check_if("discard_ack", 1'b1, 32'h200, 1'b0, 32'h0);
        cyc(0, 1);
        check_if("target200", 1'b1, 32'h204, 1'b1, 32'h200);
        check("target200.imm", o_imm, 32'h200);
        // Redirect coinciding with an ack drops that word
        i_redirect = 1'b1; i_redirectPc = 32'h300;
        cyc(0, 1);
        check_if("redir_ack", 1'b1, 32'h300, 1'b0, 32'h0);
        i_redirect = 1'b0;
        cyc(0, 1);
        check_if("target300", 1'b1, 32'h304, 1'b1, 32'h300);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
